// File: rtl/fetch_queue_if.sv
// Fetch-to-decode handshake bundle for fetch_queue.
// The master side is fetch/decode; the slave side is the queue.
interface fetch_queue_if #(
  parameter int unsigned AW = 2
);
  logic        in_valid;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_ready;
  logic        flush;
  logic [AW:0] count;

  modport master (
    output in_valid, in_pc, in_instr, out_ready, flush,
    input  in_ready, out_valid, out_pc, out_instr, count
  );

  modport slave (
    input  in_valid, in_pc, in_instr, out_ready, flush,
    output in_ready, out_valid, out_pc, out_instr, count
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction buffer between fetch and decode.
// Holds {pc, instr} pairs; in_ready low holds the PC register.
module fetch_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic          clk,
  input  logic          reset,
  fetch_queue_if.slave  q
);
  localparam logic [AW:0] FULL = DEPTH[AW:0];

  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   cnt;
  logic          ready;
  logic          valid;
  logic          push;
  logic          pop;
  logic [63:0]   head;

  // Handshake flags depend only on registered occupancy.
  assign ready = (cnt != FULL);
  assign valid = (cnt != '0);
  assign push  = q.in_valid & ready & ~q.flush;
  assign pop   = valid & q.out_ready & ~q.flush;
  assign head  = mem[rd_ptr];

  assign q.in_ready  = ready;
  assign q.out_valid = valid;
  assign q.count     = cnt;
  assign q.out_pc    = valid ? head[63:32] : '0;
  assign q.out_instr = valid ? head[31:0]  : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (q.flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage has no reset; stale entries are masked by out_valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {q.in_pc, q.in_instr};
  end
endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: expected entries queued on push,
// compared against the head when decode consumes it.
module tb_fetch_queue;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [63:0] sb [$];
  logic [31:0] last_pc;

  fetch_queue_if #(.AW(AW)) fq ();

  fetch_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .q     (fq)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return {pc[15:0] ^ 16'hBEEF, pc[31:16] ^ 16'h1357};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs();
    check("count", 64'(fq.count), 64'(sb.size()));
    check("in_ready", 64'(fq.in_ready), 64'(sb.size() != DEPTH));
    check("out_valid", 64'(fq.out_valid), 64'(sb.size() != 0));
    if (sb.size() == 0) begin
      check("empty_pc", 64'(fq.out_pc), 64'd0);
      check("empty_instr", 64'(fq.out_instr), 64'd0);
    end
  endtask

  // Called just after a falling edge; returns just after the next one.
  task automatic step(input logic v, input logic [31:0] pc, input logic rdy, input logic fl);
    logic [63:0] e;
    logic do_push, do_pop;
    fq.in_valid  = v;
    fq.in_pc     = pc;
    fq.in_instr  = instr_of(pc);
    fq.out_ready = rdy;
    fq.flush     = fl;
    #1;
    check_outputs();
    do_pop  = (sb.size() != 0) && rdy && !fl;
    do_push = v && (sb.size() != DEPTH) && !fl;
    if (do_pop) begin
      e = sb.pop_front();
      check("head_pc", 64'(fq.out_pc), 64'(e[63:32]));
      check("head_instr", 64'(fq.out_instr), 64'(e[31:0]));
    end
    if (fl) sb.delete();
    if (do_push) sb.push_back({pc, instr_of(pc)});
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 2 * DEPTH && sb.size() != 0; i++) step(1'b0, 32'd0, 1'b1, 1'b0);
    check("drained", 64'(fq.out_valid), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

  initial begin
    fq.in_valid  = 1'b0;
    fq.in_pc     = '0;
    fq.in_instr  = '0;
    fq.out_ready = 1'b0;
    fq.flush     = 1'b0;
    repeat (2) @(negedge clk);
    check_outputs();
    reset = 1'b0;

    // Asynchronous reset between edges
    for (int i = 0; i < 3; i++) step(1'b1, 32'h2000 + 32'(4 * i), 1'b0, 1'b0);
    check("pre_reset_count", 64'(fq.count), 64'd3);
    fq.in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    sb.delete();
    check("async_count", 64'(fq.count), 64'd0);
    check("async_valid", 64'(fq.out_valid), 64'd0);
    check("async_ready", 64'(fq.in_ready), 64'd1);
    check("async_instr", 64'(fq.out_instr), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Fill with decode stalled, then keep presenting 0x3010
    for (int i = 0; i < 4; i++) step(1'b1, 32'h3000 + 32'(4 * i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("full_count", 64'(fq.count), 64'd4);
      check("full_ready", 64'(fq.in_ready), 64'd0);
      check("full_head", 64'(fq.out_pc), 64'h3000);
      step(1'b1, 32'h3010, 1'b0, 1'b0);
    end

    // Drain in order
    for (int i = 0; i < 4; i++) begin
      check("drain_pc", 64'(fq.out_pc), 64'h3000 + 64'(4 * i));
      step(1'b0, 32'd0, 1'b1, 1'b0);
    end
    check("drain_valid", 64'(fq.out_valid), 64'd0);
    check("drain_instr", 64'(fq.out_instr), 64'd0);

    // Steady state at count 2 with pointer wrap
    step(1'b1, 32'h1000, 1'b0, 1'b0);
    step(1'b1, 32'h1004, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) check("pc_step", 64'(fq.out_pc), 64'(last_pc + 32'd4));
      check("steady_count", 64'(fq.count), 64'd2);
      last_pc = fq.out_pc;
      step(1'b1, 32'h1008 + 32'(4 * i), 1'b1, 1'b0);
    end
    drain();

    // Flush beats push and pop
    for (int i = 0; i < 3; i++) step(1'b1, 32'h5000 + 32'(4 * i), 1'b0, 1'b0);
    check("preflush_count", 64'(fq.count), 64'd3);
    step(1'b1, 32'h5100, 1'b1, 1'b1);
    check("flush_count", 64'(fq.count), 64'd0);
    check("flush_valid", 64'(fq.out_valid), 64'd0);
    step(1'b1, 32'h4000, 1'b0, 1'b0);
    check("postflush_valid", 64'(fq.out_valid), 64'd1);
    check("postflush_pc", 64'(fq.out_pc), 64'h4000);
    drain();

    // Full with decode ready: pop only, held entry accepted next edge
    for (int i = 0; i < 4; i++) step(1'b1, 32'h6000 + 32'(4 * i), 1'b0, 1'b0);
    step(1'b1, 32'h6010, 1'b1, 1'b0);
    check("fullpop_count", 64'(fq.count), 64'd3);
    check("fullpop_ready", 64'(fq.in_ready), 64'd1);
    step(1'b1, 32'h6010, 1'b1, 1'b0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
